// File: rtl/reg_scoreboard.sv
// In-order issue scoreboard for a 32-entry register file: counts in-flight writes
// per register and stalls issue on RAW hazards, counter saturation or flush.
module reg_scoreboard #(
    parameter int CNT_W = 2,
    parameter int TOT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic [4:0]       issue_AA,
    input  logic [4:0]       issue_BA,
    input  logic             issue_use_a,
    input  logic             issue_use_b,
    input  logic             issue_we,
    input  logic [4:0]       issue_DA,
    output logic             issue_ready,
    input  logic             RW,
    input  logic [4:0]       DA,
    input  logic             flush,
    output logic [31:0]      busy_vec,
    output logic [TOT_W-1:0] pending_total,
    output logic             wb_err
);

    localparam logic [CNT_W-1:0] MAX = '1;

    logic [CNT_W-1:0] cnt [32];
    logic [31:0]      inc_vec;
    logic [31:0]      dec_vec;
    logic             accept;
    logic             inc_any;
    logic             dec_any;
    logic             wb_under;

    // Readiness looks only at registered counts, so a same-cycle writeback never bypasses.
    always_comb begin
        issue_ready = 1'b1;
        if (issue_use_a && (cnt[issue_AA] != '0)) issue_ready = 1'b0;
        if (issue_use_b && (cnt[issue_BA] != '0)) issue_ready = 1'b0;
        if (issue_we && (cnt[issue_DA] == MAX))   issue_ready = 1'b0;
        if (flush)                                issue_ready = 1'b0;
    end

    assign accept   = issue_valid && issue_ready;
    assign wb_under = RW && (cnt[DA] == '0);

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (accept && issue_we) inc_vec[issue_DA] = 1'b1;
        if (RW && (cnt[DA] != '0)) dec_vec[DA] = 1'b1;
    end

    assign inc_any = |inc_vec;
    assign dec_any = |dec_vec;

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            busy_vec[i] = (cnt[i] != '0);
        end
    end

    // Issue and writeback to the same register cancel; an underflowing writeback is
    // dropped but still flags the sticky error. Flush wipes counts and ignores RW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                cnt[i] <= '0;
            end
            pending_total <= '0;
            wb_err        <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < 32; i++) begin
                cnt[i] <= '0;
            end
            pending_total <= '0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end else if (dec_vec[i] && !inc_vec[i]) begin
                    cnt[i] <= cnt[i] - CNT_W'(1);
                end
            end
            if (inc_any && !dec_any) begin
                pending_total <= pending_total + TOT_W'(1);
            end else if (dec_any && !inc_any) begin
                pending_total <= pending_total - TOT_W'(1);
            end
            if (wb_under) begin
                wb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed, self-checking bench for reg_scoreboard: a behavioural model pushes
// expected values into a queue and each DUT observation pops and compares one.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_AA;
    logic [4:0]  issue_BA;
    logic        issue_use_a;
    logic        issue_use_b;
    logic        issue_we;
    logic [4:0]  issue_DA;
    logic        issue_ready;
    logic        RW;
    logic [4:0]  DA;
    logic        flush;
    logic [31:0] busy_vec;
    logic [7:0]  pending_total;
    logic        wb_err;

    int          compared = 0;
    int          mismatched = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    int          m_cnt [32];
    int          m_tot;
    logic        m_err;

    reg_scoreboard #(.CNT_W(2), .TOT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_AA     (issue_AA),
        .issue_BA     (issue_BA),
        .issue_use_a  (issue_use_a),
        .issue_use_b  (issue_use_b),
        .issue_we     (issue_we),
        .issue_DA     (issue_DA),
        .issue_ready  (issue_ready),
        .RW           (RW),
        .DA           (DA),
        .flush        (flush),
        .busy_vec     (busy_vec),
        .pending_total(pending_total),
        .wb_err       (wb_err)
    );

    always #5 clk = ~clk;

    task automatic pushExpect(input string tag, input logic [31:0] value);
        tag_q.push_back(tag);
        exp_q.push_back(value);
    endtask

    task automatic checkOutput(input logic [31:0] observed);
        string       tag;
        logic [31:0] expected;
        tag      = tag_q.pop_front();
        expected = exp_q.pop_front();
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] modelBusy();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 32; i++) v[i] = (m_cnt[i] != 0);
        return v;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_tot = 0;
        m_err = 1'b0;
    endtask

    task automatic pushState(input string tag);
        pushExpect({tag, ".busy"}, modelBusy());
        pushExpect({tag, ".total"}, 32'(m_tot));
        pushExpect({tag, ".err"}, {31'b0, m_err});
    endtask

    task automatic checkState();
        checkOutput(busy_vec);
        checkOutput({24'b0, pending_total});
        checkOutput({31'b0, wb_err});
    endtask

    // One cycle: drive at the negedge, check issue_ready, clock, check state.
    task automatic applyStimulus(input logic v, input logic ua, input logic [4:0] aa,
                                 input logic ub, input logic [4:0] ba,
                                 input logic we, input logic [4:0] da,
                                 input logic rw, input logic [4:0] wda,
                                 input logic fl, input string tag);
        logic rdy;
        logic under;
        issue_valid = v;  issue_use_a = ua; issue_AA = aa;
        issue_use_b = ub; issue_BA = ba;    issue_we = we;
        issue_DA = da;    RW = rw;          DA = wda;
        flush = fl;
        #1;
        rdy = !((ua && m_cnt[aa] != 0) || (ub && m_cnt[ba] != 0) ||
                (we && m_cnt[da] == 3) || fl);
        pushExpect({tag, ".ready"}, {31'b0, rdy});
        checkOutput({31'b0, issue_ready});
        @(posedge clk);
        if (fl) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            m_tot = 0;
        end else begin
            under = rw && (m_cnt[wda] == 0);
            if (rw && !under) begin
                m_cnt[wda]--;
                m_tot--;
            end
            if (v && rdy && we) begin
                m_cnt[da]++;
                m_tot++;
            end
            if (under) m_err = 1'b1;
        end
        #1;
        pushState(tag);
        checkState();
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, tag);
    endtask

    task automatic issueWrite(input logic [4:0] da, input string tag);
        applyStimulus(1, 0, 5'd0, 0, 5'd0, 1, da, 0, 5'd0, 0, tag);
    endtask

    initial begin
        rst_n = 1'b0;
        issue_valid = 0; issue_use_a = 0; issue_AA = 0; issue_use_b = 0; issue_BA = 0;
        issue_we = 0; issue_DA = 0; RW = 0; DA = 0; flush = 0;
        modelReset();
        repeat (2) @(negedge clk);
        #1;
        pushState("reset");
        checkState();
        pushExpect("reset.ready", 32'd1);
        checkOutput({31'b0, issue_ready});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // RAW on R3: ready stays low through the writeback cycle, rises the cycle after
        issueWrite(5'd3, "raw_issue");
        applyStimulus(1, 1, 5'd3, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, "raw_stall1");
        applyStimulus(1, 1, 5'd3, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, "raw_stall2");
        applyStimulus(1, 1, 5'd3, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, "raw_stall3");
        applyStimulus(1, 1, 5'd3, 0, 5'd0, 0, 5'd0, 1, 5'd3, 0, "raw_wb_nobypass");
        applyStimulus(1, 1, 5'd3, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, "raw_release");

        // Saturation of R7 at three outstanding writes
        issueWrite(5'd7, "sat1");
        issueWrite(5'd7, "sat2");
        issueWrite(5'd7, "sat3");
        issueWrite(5'd7, "sat4_blocked");
        applyStimulus(1, 0, 5'd0, 0, 5'd0, 1, 5'd7, 1, 5'd7, 0, "sat_wb_blocked");
        issueWrite(5'd7, "sat_reissue");

        // Source B hazard
        applyStimulus(1, 0, 5'd0, 1, 5'd7, 0, 5'd0, 0, 5'd0, 0, "rawb_stall");

        // Same-cycle issue and writeback, same and different registers
        issueWrite(5'd9, "same_issue9");
        applyStimulus(1, 0, 5'd0, 0, 5'd0, 1, 5'd9, 1, 5'd9, 0, "same_reg_net0");
        applyStimulus(1, 0, 5'd0, 0, 5'd0, 1, 5'd4, 1, 5'd9, 0, "diff_reg");

        // Flush with a concurrent writeback to an idle register: no error raised
        applyStimulus(1, 0, 5'd0, 0, 5'd0, 1, 5'd5, 1, 5'd2, 1, "flush");
        idle("post_flush");

        // Underflow with a same-cycle issue, then sticky through flush
        applyStimulus(1, 0, 5'd0, 0, 5'd0, 1, 5'd12, 1, 5'd12, 0, "underflow_issue");
        applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, "err_flush");
        applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 5'd12, 0, "underflow_plain");
        idle("err_sticky");

        // R0 is an ordinary register
        issueWrite(5'd0, "r0_issue");
        applyStimulus(1, 0, 5'd0, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, "r0_raw");

        // Mid-run asynchronous reset with five writes pending
        issueWrite(5'd1, "pend1");
        issueWrite(5'd2, "pend2");
        issueWrite(5'd2, "pend3");
        issueWrite(5'd30, "pend4");
        issue_valid = 0; issue_we = 0; issue_use_a = 0; issue_use_b = 0; RW = 0; flush = 0;
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        pushState("async_reset");
        checkState();
        pushExpect("async_reset.ready", 32'd1);
        checkOutput({31'b0, issue_ready});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        idle("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
